image_tx_ctrl: RTL and testbench



---
 rtl/image_tx_pkg.sv | 19 +
 rtl/tx_unpack_128to64.sv | 57 +++++
 rtl/image_tx_ctrl.sv | 160 ++++++++++++++++
 tb/tb_image_tx_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_tx_pkg.sv
// Shared constants and FSM encodings for the 128-bit FIFO to RIFFA TX frame path.
package image_tx_pkg;

    localparam int DW_PER_WORD    = 4;
    localparam int BEATS_PER_WORD = 2;
    localparam int LEN_W          = 32;
    localparam int DIM_W          = 18;
    localparam int WORD_W         = 128;
    localparam int BEAT_W         = 64;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_CALC = 3'd1;
    localparam state_t ST_REQ  = 3'd2;
    localparam state_t ST_DATA = 3'd3;
    localparam state_t ST_DONE = 3'd4;

endpackage

// File: rtl/tx_unpack_128to64.sv
// Splits each FWFT FIFO word into two 64-bit beats, low half first, refilling
// from the FIFO in the same cycle the held word is consumed so there is no bubble.
module tx_unpack_128to64
    import image_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              words_avail,
    input  logic              rd_empty,
    input  logic [WORD_W-1:0] rd_data,
    input  logic              ren,
    output logic              rd_en,
    output logic [BEAT_W-1:0] data,
    output logic              valid,
    output logic              accept
);

    logic [WORD_W-1:0] hold_q, hold_d;
    logic              hv_q, hv_d;
    logic              hs_q, hs_d;
    logic              consume;

    assign valid   = hv_q;
    assign data    = hs_q ? hold_q[WORD_W-1:BEAT_W] : hold_q[BEAT_W-1:0];
    assign accept  = hv_q & ren;
    assign consume = accept & hs_q;
    assign rd_en   = en & (~hv_q | consume) & ~rd_empty & words_avail;

    always_comb begin
        hold_d = hold_q;
        hv_d   = hv_q;
        hs_d   = hs_q;
        if (accept) begin
            hs_d = ~hs_q;
        end
        if (rd_en) begin
            hold_d = rd_data;
            hv_d   = 1'b1;
        end else if (consume) begin
            hv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            hv_q   <= 1'b0;
            hs_q   <= 1'b0;
        end else begin
            hold_q <= hold_d;
            hv_q   <= hv_d;
            hs_q   <= hs_d;
        end
    end

endmodule

// File: rtl/image_tx_ctrl.sv
// Sizes one frame from WIDTH x HEIGHT, runs the RIFFA CHNL_TX request/ACK
// handshake and streams the frame from the FWFT FIFO as 64-bit beats.
module image_tx_ctrl
    import image_tx_pkg::*;
#(
    parameter int unsigned BUSY_TIMEOUT = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FRAME_START,
    input  logic [31:0]       WIDTH,
    input  logic [31:0]       HEIGHT,
    input  logic              RD_EMPTY,
    input  logic [WORD_W-1:0] RD_DATA,
    output logic              RD_EN,
    output logic              CHNL_TX_CLK,
    output logic              CHNL_TX,
    input  logic              CHNL_TX_ACK,
    output logic              CHNL_TX_LAST,
    output logic [31:0]       CHNL_TX_LEN,
    output logic [30:0]       CHNL_TX_OFF,
    output logic [BEAT_W-1:0] CHNL_TX_DATA,
    output logic              CHNL_TX_DATA_VALID,
    input  logic              CHNL_TX_DATA_REN,
    output logic              BUSY,
    output logic              FRAME_DONE,
    output logic              ERR
);

    localparam logic [LEN_W-1:0] TMO = LEN_W'(BUSY_TIMEOUT);

    state_t             state_q, state_d;
    logic [DIM_W-1:0]   w_q, w_d, h_q, h_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-2:0]   beats_left_q, beats_left_d;
    logic [LEN_W-3:0]   words_left_q, words_left_d;
    logic [LEN_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               err_q, err_d;
    logic [2*DIM_W-1:0] product;
    logic [LEN_W-1:0]   len_trunc;
    logic               calc_bad;
    logic               in_tx, accept, rd_en_int;
    logic               unused_dims;

    assign unused_dims = ^{WIDTH[31:DIM_W], HEIGHT[31:DIM_W]};

    assign product   = (2*DIM_W)'(w_q) * (2*DIM_W)'(h_q);
    assign len_trunc = product[LEN_W-1:0];
    // Length must be whole 128-bit words and must fit the 32-bit LEN field.
    assign calc_bad  = (len_trunc == '0) || (len_trunc[1:0] != 2'b00) ||
                       (product[2*DIM_W-1:LEN_W] != '0);

    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        h_d          = h_q;
        len_d        = len_q;
        beats_left_d = beats_left_q;
        words_left_d = words_left_q;
        wait_cnt_d   = wait_cnt_q;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (FRAME_START) begin
                    w_d     = WIDTH[DIM_W-1:0];
                    h_d     = HEIGHT[DIM_W-1:0];
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                len_d = len_trunc;
                if (calc_bad) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    beats_left_d = len_trunc[LEN_W-1:1];
                    words_left_d = len_trunc[LEN_W-1:2];
                    wait_cnt_d   = '0;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (CHNL_TX_ACK) begin
                    state_d = ST_DATA;
                end else if (TMO != '0) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_d == TMO) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (rd_en_int) begin
                    words_left_d = words_left_q - 1'b1;
                end
                if (accept) begin
                    beats_left_d = beats_left_q - 1'b1;
                    if (beats_left_q == (LEN_W-1)'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            w_q          <= '0;
            h_q          <= '0;
            len_q        <= '0;
            beats_left_q <= '0;
            words_left_q <= '0;
            wait_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            h_q          <= h_d;
            len_q        <= len_d;
            beats_left_q <= beats_left_d;
            words_left_q <= words_left_d;
            wait_cnt_q   <= wait_cnt_d;
            err_q        <= err_d;
        end
    end

    tx_unpack_128to64 u_unpack (
        .clk         (CLK),
        .rst         (RST),
        .en          (state_q == ST_DATA),
        .words_avail (words_left_q != '0),
        .rd_empty    (RD_EMPTY),
        .rd_data     (RD_DATA),
        .ren         (CHNL_TX_DATA_REN),
        .rd_en       (rd_en_int),
        .data        (CHNL_TX_DATA),
        .valid       (CHNL_TX_DATA_VALID),
        .accept      (accept)
    );

    assign in_tx        = (state_q == ST_REQ) || (state_q == ST_DATA);
    assign RD_EN        = rd_en_int;
    assign CHNL_TX_CLK  = CLK;
    assign CHNL_TX      = in_tx;
    assign CHNL_TX_LAST = in_tx;
    assign CHNL_TX_LEN  = in_tx ? len_q : '0;
    assign CHNL_TX_OFF  = '0;
    assign BUSY         = (state_q != ST_IDLE);
    assign FRAME_DONE   = (state_q == ST_DONE);
    assign ERR          = err_q;

endmodule

// File: tb/tb_image_tx_ctrl.sv
// Scoreboard bench for image_tx_ctrl: FIFO model, expected-beat queue, one task per scenario.
module tb_image_tx_ctrl;

    logic         CLK = 1'b0;
    logic         RST;
    logic         FRAME_START;
    logic [31:0]  WIDTH, HEIGHT;
    logic         RD_EMPTY;
    logic [127:0] RD_DATA;
    logic         RD_EN;
    logic         CHNL_TX_CLK, CHNL_TX, CHNL_TX_ACK, CHNL_TX_LAST;
    logic [31:0]  CHNL_TX_LEN;
    logic [30:0]  CHNL_TX_OFF;
    logic [63:0]  CHNL_TX_DATA;
    logic         CHNL_TX_DATA_VALID, CHNL_TX_DATA_REN;
    logic         BUSY, FRAME_DONE, ERR;

    logic [127:0] fifo_q[$];
    logic [127:0] feed_q[$];
    logic [63:0]  exp_q[$];
    logic [63:0]  obs_q[$];
    int           feed_gap, feed_tmr;
    int           checks, passed;

    always #5 CLK = ~CLK;

    image_tx_ctrl #(.BUSY_TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST), .FRAME_START(FRAME_START), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
        .RD_EMPTY(RD_EMPTY), .RD_DATA(RD_DATA), .RD_EN(RD_EN), .CHNL_TX_CLK(CHNL_TX_CLK),
        .CHNL_TX(CHNL_TX), .CHNL_TX_ACK(CHNL_TX_ACK), .CHNL_TX_LAST(CHNL_TX_LAST),
        .CHNL_TX_LEN(CHNL_TX_LEN), .CHNL_TX_OFF(CHNL_TX_OFF), .CHNL_TX_DATA(CHNL_TX_DATA),
        .CHNL_TX_DATA_VALID(CHNL_TX_DATA_VALID), .CHNL_TX_DATA_REN(CHNL_TX_DATA_REN),
        .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .ERR(ERR)
    );

    task automatic fifo_drive();
        RD_EMPTY = (fifo_q.size() == 0);
        RD_DATA  = (fifo_q.size() == 0) ? 128'd0 : fifo_q[0];
    endtask

    // One clock: drive inputs at negedge, sample outputs, then update the FIFO model after posedge.
    task automatic cycle(input logic st, input logic ren, input logic ack,
                         output logic vld, output logic acc, output logic [63:0] beat,
                         output logic pop);
        logic [127:0] w;
        @(negedge CLK);
        FRAME_START = st;
        CHNL_TX_DATA_REN = ren;
        CHNL_TX_ACK = ack;
        #1;
        vld  = CHNL_TX_DATA_VALID;
        acc  = CHNL_TX_DATA_VALID & ren;
        beat = CHNL_TX_DATA;
        pop  = RD_EN;
        @(posedge CLK);
        #1;
        FRAME_START = 1'b0;
        CHNL_TX_ACK = 1'b0;
        if (pop && fifo_q.size() != 0) w = fifo_q.pop_front();
        if (feed_q.size() != 0) begin
            feed_tmr++;
            if (feed_tmr >= feed_gap) begin
                fifo_q.push_back(feed_q.pop_front());
                feed_tmr = 0;
            end
        end
        fifo_drive();
    endtask

    task automatic load_frame(input int n_words, input bit preload);
        logic [63:0] lo, hi;
        for (int i = 0; i < n_words; i++) begin
            lo = {$urandom, $urandom};
            hi = {$urandom, $urandom};
            if (preload) fifo_q.push_back({hi, lo});
            else         feed_q.push_back({hi, lo});
            exp_q.push_back(lo);
            exp_q.push_back(hi);
        end
        feed_tmr = 0;
        fifo_drive();
    endtask

    task automatic start_frame(input logic [31:0] w, input logic [31:0] h, output logic tx_t1);
        logic v, a, p;
        logic [63:0] b;
        WIDTH  = w;
        HEIGHT = h;
        cycle(1'b1, 1'b1, 1'b0, v, a, b, p);
        tx_t1 = CHNL_TX;
        cycle(1'b0, 1'b1, 1'b0, v, a, b, p);
    endtask

    task automatic ack_cycle();
        logic v, a, p;
        logic [63:0] b;
        cycle(1'b0, 1'b1, 1'b1, v, a, b, p);
    endtask

    // Runs the DATA phase (bounded) and records observed beats into obs_q.
    task automatic run_data(input bit toggle_ren, output int n_pop, output int n_acc,
                            output int first_vld, output int last_acc, output int done_at,
                            output int gaps, output bit busy_drop, output logic tx_at_done);
        logic v, a, p, ren;
        logic [63:0] b;
        n_pop = 0; n_acc = 0; first_vld = -1; last_acc = -1; done_at = -1;
        gaps = 0; busy_drop = 0; tx_at_done = 1'bx;
        for (int i = 0; i < 200; i++) begin
            ren = toggle_ren ? ((i % 2) == 0) : 1'b1;
            cycle(1'b0, ren, 1'b0, v, a, b, p);
            if (v && first_vld < 0) first_vld = i;
            if (!v && first_vld >= 0) gaps++;
            if (a) begin
                obs_q.push_back(b);
                n_acc++;
                last_acc = i;
            end
            if (p) n_pop++;
            if (FRAME_DONE) begin
                done_at = i;
                tx_at_done = CHNL_TX;
                break;
            end
            if (!BUSY) busy_drop = 1;
        end
    endtask

    task automatic compare_beats(input string tag);
        logic [63:0] e, o;
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) $display("FAIL %s beat: got %h expected %h", tag, o, e);
            else passed++;
        end
        checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0)
            $display("FAIL %s leftover: exp_q=%0d obs_q=%0d expected 0/0", tag, exp_q.size(), obs_q.size());
        else passed++;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        FRAME_START = 0; WIDTH = 0; HEIGHT = 0; CHNL_TX_ACK = 0; CHNL_TX_DATA_REN = 0;
        fifo_drive();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({RD_EN, CHNL_TX, CHNL_TX_LAST, CHNL_TX_DATA_VALID, BUSY, FRAME_DONE, ERR} !== 7'd0)
            $display("FAIL reset_flags: got %b expected 0000000",
                     {RD_EN, CHNL_TX, CHNL_TX_LAST, CHNL_TX_DATA_VALID, BUSY, FRAME_DONE, ERR});
        else passed++;
        checks++;
        if ({CHNL_TX_LEN, CHNL_TX_OFF, CHNL_TX_DATA} !== 127'd0)
            $display("FAIL reset_buses: len=%h off=%h data=%h expected 0", CHNL_TX_LEN, CHNL_TX_OFF, CHNL_TX_DATA);
        else passed++;
        checks++;
        if (CHNL_TX_CLK !== CLK) $display("FAIL tx_clk: got %b expected %b", CHNL_TX_CLK, CLK);
        else passed++;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic nominal_frame(input string tag, input bit toggle_ren, input bit preload, input int gap);
        logic tx1, txd;
        int n_pop, n_acc, fv, la, da, gaps;
        bit bdrop;
        feed_gap = gap;
        load_frame(4, preload);
        start_frame(32'd8, 32'd2, tx1);
        checks++;
        if (tx1 !== 1'b0) $display("FAIL %s tx_t1: got %b expected 0", tag, tx1);
        else passed++;
        checks++;
        if ({CHNL_TX, CHNL_TX_LAST, BUSY, CHNL_TX_LEN, CHNL_TX_OFF} !== {3'b111, 32'd16, 31'd0})
            $display("FAIL %s req: tx=%b last=%b busy=%b len=%0d off=%0d expected 1 1 1 16 0",
                     tag, CHNL_TX, CHNL_TX_LAST, BUSY, CHNL_TX_LEN, CHNL_TX_OFF);
        else passed++;
        ack_cycle();
        run_data(toggle_ren, n_pop, n_acc, fv, la, da, gaps, bdrop, txd);
        checks++;
        if (n_acc !== 8) $display("FAIL %s beats: got %0d expected 8", tag, n_acc);
        else passed++;
        checks++;
        if (n_pop !== 4) $display("FAIL %s rd_en_count: got %0d expected 4", tag, n_pop);
        else passed++;
        checks++;
        if (da < 0 || da !== la) $display("FAIL %s done_timing: done_at=%0d expected %0d", tag, da, la);
        else passed++;
        checks++;
        if (txd !== 1'b0) $display("FAIL %s tx_at_done: got %b expected 0", tag, txd);
        else passed++;
        checks++;
        if (bdrop) $display("FAIL %s busy_drop: got 1 expected 0", tag);
        else passed++;
        if (preload) begin
            checks++;
            if (fv !== 1) $display("FAIL %s first_valid: got %0d expected 1", tag, fv);
            else passed++;
        end
        if (gap > 1) begin
            checks++;
            if (gaps == 0) $display("FAIL %s underrun_gaps: got 0 expected >0", tag);
            else passed++;
        end
        compare_beats(tag);
        ack_cycle();
        checks++;
        if ({FRAME_DONE, BUSY} !== 2'b00) $display("FAIL %s idle_after: done=%b busy=%b expected 0 0", tag, FRAME_DONE, BUSY);
        else passed++;
    endtask

    task automatic test_nominal();      nominal_frame("nominal", 1'b0, 1'b1, 1); endtask
    task automatic test_back_pressure(); nominal_frame("backpressure", 1'b1, 1'b1, 1); endtask
    task automatic test_underrun();     nominal_frame("underrun", 1'b0, 1'b0, 5); endtask

    task automatic test_reject();
        logic [31:0] wt[3] = '{32'd3, 32'd0, 32'h20000};
        logic [31:0] ht[3] = '{32'd1, 32'd5, 32'h20000};
        logic tx1;
        for (int i = 0; i < 3; i++) begin
            start_frame(wt[i], ht[i], tx1);
            checks++;
            if ({ERR, CHNL_TX, tx1} !== 3'b100)
                $display("FAIL reject%0d: err=%b tx=%b tx_t1=%b expected 1 0 0", i, ERR, CHNL_TX, tx1);
            else passed++;
            ack_cycle();
            checks++;
            if ({ERR, BUSY} !== 2'b00) $display("FAIL reject%0d_after: err=%b busy=%b expected 0 0", i, ERR, BUSY);
            else passed++;
        end
    endtask

    task automatic test_timeout();
        logic tx1, v, a, p;
        logic [63:0] b;
        int k;
        start_frame(32'd8, 32'd2, tx1);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b0, 1'b1, 1'b0, v, a, b, p);
            if (ERR) begin
                k = i;
                break;
            end
        end
        checks++;
        if (k !== 16) $display("FAIL timeout_cycles: got %0d expected 16", k);
        else passed++;
        checks++;
        if ({CHNL_TX, BUSY} !== 2'b00) $display("FAIL timeout_state: tx=%b busy=%b expected 0 0", CHNL_TX, BUSY);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic tx1, v, a, p;
        logic [63:0] b;
        int n;
        load_frame(4, 1'b1);
        start_frame(32'd8, 32'd2, tx1);
        ack_cycle();
        n = 0;
        for (int i = 0; i < 50 && n < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, v, a, b, p);
            if (a) n++;
        end
        checks++;
        if (n !== 3) $display("FAIL mid_beats: got %0d expected 3", n);
        else passed++;
        RST = 1'b1;
        #1;
        checks++;
        if ({RD_EN, CHNL_TX, CHNL_TX_LAST, CHNL_TX_DATA_VALID, BUSY, FRAME_DONE, ERR, CHNL_TX_LEN, CHNL_TX_DATA} !== 103'd0)
            $display("FAIL mid_reset_outputs: flags=%b len=%h data=%h expected 0",
                     {RD_EN, CHNL_TX, CHNL_TX_LAST, CHNL_TX_DATA_VALID, BUSY, FRAME_DONE, ERR}, CHNL_TX_LEN, CHNL_TX_DATA);
        else passed++;
        @(negedge CLK);
        RST = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        obs_q.delete();
        fifo_drive();
        nominal_frame("after_reset", 1'b0, 1'b1, 1);
    endtask

    initial begin
        checks = 0; passed = 0; feed_gap = 1; feed_tmr = 0;
        test_reset();
        test_nominal();
        test_back_pressure();
        test_underrun();
        test_reject();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
